// File: rtl/cache_bridge_pkg.sv
// Purpose: shared state encoding and fixed AXI attributes for the cache line bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    AW,
    W,
    B,
    AR,
    R,
    DONE
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_64    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/cache_line_bridge_line_buffer.sv
// Purpose: LINE_BEATS x 64 line storage, one write port, two combinational read ports.
// Latency: write lands at the next clk edge; reads are combinational.
// Backpressure: none; the caller arbitrates the single write port.
module line_buffer #(
  parameter int LINE_BEATS = 8,
  parameter int IDX_W      = $clog2(LINE_BEATS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [63:0]      wdata,
  input  logic [IDX_W-1:0] ridx_a,
  output logic [63:0]      rdata_a,
  input  logic [IDX_W-1:0] ridx_b,
  output logic [63:0]      rdata_b
);

  logic [63:0] mem [LINE_BEATS];

  // Line contents are deliberately not reset; a line is always fully rewritten before use.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata_a = mem[ridx_a];
  assign rdata_b = mem[ridx_b];

endmodule

// File: rtl/cache_line_bridge.sv
// Purpose: turns one cache line request into one AXI4 INCR burst (refill or write-back); optional CACHE_LINE_BRIDGE_TIMEOUT_EN adds a 16-bit bus watchdog.
// Latency: refill AR accept -> axi_done LINE_BEATS+1 cycles; write-back last cache beat -> axi_done LINE_BEATS+3 cycles (zero-wait memory).
// Backpressure: one transaction outstanding; valids are registered state decodes and hold until their handshake.
module cache_line_bridge
  import cache_bridge_pkg::*;
#(
  parameter int LINE_BEATS = 8,
  parameter int IDX_W      = $clog2(LINE_BEATS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             axi_req,
  input  logic             axi_rw,
  input  logic [63:0]      axi_req_addr,
  input  logic             axi_fifo_wen,
  input  logic [63:0]      axi_fifo_data_i,
  input  logic [IDX_W-1:0] axi_fifo_ridx,
  input  logic             axi_fifo_done,
  output logic [63:0]      axi_data_o,
  output logic             axi_done,
  output logic             bus_err,
  output logic             m_awvalid,
  input  logic             m_awready,
  output logic [63:0]      m_awaddr,
  output logic [7:0]       m_awlen,
  output logic             m_wvalid,
  input  logic             m_wready,
  output logic [63:0]      m_wdata,
  output logic [7:0]       m_wstrb,
  output logic             m_wlast,
  input  logic             m_bvalid,
  output logic             m_bready,
  input  logic [1:0]       m_bresp,
  output logic             m_arvalid,
  input  logic             m_arready,
  output logic [63:0]      m_araddr,
  output logic [7:0]       m_arlen,
  input  logic             m_rvalid,
  output logic             m_rready,
  input  logic [63:0]      m_rdata,
  input  logic [1:0]       m_rresp,
  input  logic             m_rlast
);

  localparam int               OFF_W     = IDX_W + 3;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_BEATS - 1);
  localparam logic [IDX_W:0]   FULL      = (IDX_W+1)'(LINE_BEATS);
  localparam logic [IDX_W:0]   FULL_M1   = (IDX_W+1)'(LINE_BEATS - 1);
  localparam logic [63:0]      LINE_MASK = ~((64'd1 << OFF_W) - 64'd1);

  state_t           state, state_nxt;
  logic [IDX_W:0]   wptr;
  logic [IDX_W-1:0] beat;
  logic [63:0]      addr_q;
  logic             cache_wr;
  logic             r_hs;
  logic             r_last;
  logic             tmo_hit;

  assign cache_wr = (state == IDLE || state == COLLECT) && axi_fifo_wen && (wptr < FULL);
  assign r_hs     = (state == R) && m_rvalid;
  assign r_last   = r_hs && (m_rlast || beat == LAST_BEAT);

  assign m_awaddr = addr_q;
  assign m_araddr = addr_q;
  assign m_awlen  = 8'(LINE_BEATS - 1);
  assign m_arlen  = 8'(LINE_BEATS - 1);
  assign m_wstrb  = 8'hFF;
  assign m_wlast  = (state == W) && (beat == LAST_BEAT);

  line_buffer #(.LINE_BEATS(LINE_BEATS), .IDX_W(IDX_W)) u_buf (
    .clk     (clk),
    .we      (cache_wr | r_hs),
    .widx    (r_hs ? beat : wptr[IDX_W-1:0]),
    .wdata   (r_hs ? m_rdata : axi_fifo_data_i),
    .ridx_a  (axi_fifo_ridx),
    .rdata_a (axi_data_o),
    .ridx_b  (beat),
    .rdata_b (m_wdata)
  );

`ifdef CACHE_LINE_BRIDGE_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        bus_active;
  logic        bus_hs;

  assign bus_active = state inside {AW, W, B, AR, R};
  assign bus_hs     = (state == AW && m_awready) || (state == W && m_wready) ||
                      (state == B && m_bvalid)   || (state == AR && m_arready) || r_hs;
  assign tmo_hit    = bus_active && !bus_hs && (tmo_cnt == 16'hFFFF);

  // Watchdog: counts idle bus cycles, restarts on any handshake or outside bus states.
  always_ff @(posedge clk) begin
    if (!rst) tmo_cnt <= '0;
    else if (!bus_active || bus_hs || tmo_hit) tmo_cnt <= '0;
    else tmo_cnt <= tmo_cnt + 16'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register plus pointers, latched address and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      wptr    <= '0;
      beat    <= '0;
      addr_q  <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && axi_req) addr_q <= axi_req_addr & LINE_MASK;
      if (cache_wr) wptr <= wptr + (IDX_W+1)'(1);
      if ((state == W && m_wready) || r_hs) beat <= beat + IDX_W'(1);
      if (tmo_hit) bus_err <= 1'b1;
      if (state == B && m_bvalid && m_bresp != AXI_RESP_OKAY) bus_err <= 1'b1;
      if (r_hs && (m_rresp != AXI_RESP_OKAY || (m_rlast && beat != LAST_BEAT))) bus_err <= 1'b1;
      if (state == DONE && axi_fifo_done) begin
        bus_err <= 1'b0;
        wptr    <= '0;
        beat    <= '0;
      end
    end
  end

  // Next state and state-decoded handshake outputs; no ready feeds any valid.
  always_comb begin
    state_nxt = state;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    axi_done  = 1'b0;
    unique case (state)
      IDLE:    if (axi_req) state_nxt = axi_rw ? COLLECT : AR;
      // Look one beat ahead so AW issues right after the final cache beat lands.
      COLLECT: if (wptr == FULL || (cache_wr && wptr == FULL_M1)) state_nxt = AW;
      AW: begin
        m_awvalid = 1'b1;
        if (m_awready) state_nxt = W;
      end
      W: begin
        m_wvalid = 1'b1;
        if (m_wready && beat == LAST_BEAT) state_nxt = B;
      end
      B: begin
        m_bready = 1'b1;
        if (m_bvalid) state_nxt = DONE;
      end
      AR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_nxt = R;
      end
      R: begin
        m_rready = 1'b1;
        if (r_last) state_nxt = DONE;
      end
      DONE: begin
        axi_done = 1'b1;
        if (axi_fifo_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (tmo_hit) state_nxt = DONE;
  end

endmodule

// File: tb/tb_cache_line_bridge.sv
// Purpose: self-checking bench for cache_line_bridge with a queue scoreboard of expected beats.
// Latency: checks refill and write-back done latency against zero-wait figures.
// Backpressure: exercises toggling wready, error responses, early rlast and mid-burst reset.
module tb_cache_line_bridge;

  localparam int LB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        axi_req, axi_rw, axi_fifo_wen, axi_fifo_done;
  logic [63:0] axi_req_addr, axi_fifo_data_i, axi_data_o;
  logic [2:0]  axi_fifo_ridx;
  logic        axi_done, bus_err;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
  logic [63:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [7:0]  m_awlen, m_arlen, m_wstrb;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [1:0]  m_bresp, m_rresp;

  int checks = 0;
  int fails  = 0;
  int lat;

  logic [63:0] exp_q[$];
  logic [63:0] obs_w[$];
  logic        obs_last[$];
  logic [63:0] obs_awaddr, obs_araddr;
  bit          obs_w_stable, obs_rready_ok;

  cache_line_bridge #(.LINE_BEATS(LB)) dut (
    .clk(clk), .rst(rst),
    .axi_req(axi_req), .axi_rw(axi_rw), .axi_req_addr(axi_req_addr),
    .axi_fifo_wen(axi_fifo_wen), .axi_fifo_data_i(axi_fifo_data_i),
    .axi_fifo_ridx(axi_fifo_ridx), .axi_fifo_done(axi_fifo_done),
    .axi_data_o(axi_data_o), .axi_done(axi_done), .bus_err(bus_err),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast)
  );

  always #5 clk = ~clk;

  // Cache side: push n write-back beats, optionally raising the request with the first one.
  task automatic push_line(input logic [63:0] addr, input logic [63:0] base, input int n, input bit with_req);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      axi_fifo_wen    = 1'b1;
      axi_fifo_data_i = base + 64'(i);
      if (i < LB) exp_q.push_back(base + 64'(i));
      axi_req      = with_req && (i == 0);
      axi_rw       = 1'b1;
      axi_req_addr = addr;
    end
  endtask

  // Memory side for a write-back: records AW address and W beats until axi_done.
  task automatic serve_write(input bit toggle, input logic [1:0] bresp, output int l);
    bit seen_last = 1'b0;
    bit pend_w    = 1'b0;
    logic [63:0] prev_d = '0;
    obs_w.delete();
    obs_last.delete();
    obs_w_stable = 1'b1;
    obs_awaddr   = '0;
    l = -1;
    m_wready = 1'b0;
    for (int g = 1; g <= 300; g++) begin
      @(negedge clk);
      axi_fifo_wen = 1'b0;
      axi_req      = 1'b0;
      if (axi_done) begin
        l = g;
        break;
      end
      if (pend_w && (!m_wvalid || m_wdata !== prev_d)) obs_w_stable = 1'b0;
      m_awready = 1'b1;
      m_wready  = toggle ? ~m_wready : 1'b1;
      m_bvalid  = seen_last;
      m_bresp   = bresp;
      if (m_awvalid) obs_awaddr = m_awaddr;
      pend_w = m_wvalid && !m_wready;
      prev_d = m_wdata;
      if (m_wvalid && m_wready) begin
        obs_w.push_back(m_wdata);
        obs_last.push_back(m_wlast);
        if (m_wlast) seen_last = 1'b1;
      end
    end
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    m_bresp   = 2'b00;
  endtask

  // Memory side for a refill: accept AR, stream beats 0..last_at, then wait for axi_done.
  task automatic serve_read(input logic [63:0] rbase, input int last_at, output int l);
    int g = 0;
    l = -1;
    obs_rready_ok = 1'b1;
    obs_araddr    = '0;
    while (!m_arvalid && g < 50) begin
      @(negedge clk);
      axi_req = 1'b0;
      g++;
    end
    if (!m_arvalid) return;
    obs_araddr = m_araddr;
    m_arready  = 1'b1;
    for (int i = 0; i <= last_at; i++) begin
      @(negedge clk);
      m_arready = 1'b0;
      if (!m_rready) obs_rready_ok = 1'b0;
      m_rvalid = 1'b1;
      m_rdata  = rbase + 64'(i);
      m_rlast  = (i == last_at);
      m_rresp  = 2'b00;
      exp_q.push_back(rbase + 64'(i));
    end
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      m_rdata  = '0;
      if (axi_done) begin
        l = last_at + 1 + k;
        break;
      end
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    axi_fifo_done = 1'b1;
    @(negedge clk);
    axi_fifo_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    axi_req = 0; axi_rw = 0; axi_req_addr = '0; axi_fifo_wen = 0; axi_fifo_data_i = '0;
    axi_fifo_ridx = '0; axi_fifo_done = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0; m_arready = 0;
    m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, axi_done, bus_err} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, axi_done, bus_err});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (m_wstrb !== 8'hFF) begin fails++; $display("FAIL wstrb: got %h expected ff", m_wstrb); end
    checks++;
    if (m_awlen !== 8'd7 || m_arlen !== 8'd7) begin
      fails++; $display("FAIL burst_len: got aw %0d ar %0d expected 7", m_awlen, m_arlen);
    end
  endtask

  task automatic test_refill();
    logic [63:0] e;
    @(negedge clk);
    axi_req = 1'b1; axi_rw = 1'b0; axi_req_addr = 64'h8000_1234;
    serve_read(64'd0, 7, lat);
    checks++;
    if (obs_araddr !== 64'h8000_1200) begin fails++; $display("FAIL refill_araddr: got %h expected 80001200", obs_araddr); end
    checks++;
    if (!obs_rready_ok) begin fails++; $display("FAIL refill_rready: got 0 expected 1 on every beat"); end
    checks++;
    if (lat != 9) begin fails++; $display("FAIL refill_latency: got %0d expected 9", lat); end
    checks++;
    if ({axi_done, bus_err} !== 2'b10) begin fails++; $display("FAIL refill_done: got %b expected 10", {axi_done, bus_err}); end
    for (int i = 0; i < LB; i++) begin
      axi_fifo_ridx = 3'(i);
      #1;
      checks++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      if (axi_data_o !== e) begin fails++; $display("FAIL refill_rd%0d: got %h expected %h", i, axi_data_o, e); end
    end
    do_ack();
    checks++;
    if ({axi_done, m_rready, bus_err} !== 3'b0) begin fails++; $display("FAIL refill_ack: got %b expected 000", {axi_done, m_rready, bus_err}); end
  endtask

  task automatic test_writeback();
    logic [63:0] e;
    push_line(64'h4000_00F8, 64'hA0, LB, 1'b1);
    serve_write(1'b1, 2'b00, lat);
    checks++;
    if (lat < 0) begin fails++; $display("FAIL wb_done: got timeout expected axi_done"); end
    checks++;
    if (obs_awaddr !== 64'h4000_00C0) begin fails++; $display("FAIL wb_awaddr: got %h expected 400000c0", obs_awaddr); end
    checks++;
    if (obs_w.size() != LB) begin fails++; $display("FAIL wb_count: got %0d expected %0d", obs_w.size(), LB); end
    for (int i = 0; i < obs_w.size(); i++) begin
      checks++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      if (obs_w[i] !== e || obs_last[i] !== (i == LB - 1)) begin
        fails++; $display("FAIL wb_beat%0d: got %h last %b expected %h last %b", i, obs_w[i], obs_last[i], e, i == LB - 1);
      end
    end
    checks++;
    if (!obs_w_stable) begin fails++; $display("FAIL wb_wvalid_hold: got dropped/changed beat expected stable"); end
    checks++;
    if ({axi_done, bus_err} !== 2'b10) begin fails++; $display("FAIL wb_status: got %b expected 10", {axi_done, bus_err}); end
    do_ack();
    exp_q.delete();
  endtask

  task automatic test_bresp_err();
    push_line(64'h1000_0000, 64'hB0, LB, 1'b1);
    serve_write(1'b0, 2'b10, lat);
    exp_q.delete();
    checks++;
    if (lat != 11) begin fails++; $display("FAIL wb_latency: got %0d expected 11", lat); end
    checks++;
    if ({axi_done, bus_err} !== 2'b11) begin fails++; $display("FAIL bresp_err: got %b expected 11", {axi_done, bus_err}); end
    do_ack();
    checks++;
    if ({axi_done, bus_err} !== 2'b00) begin fails++; $display("FAIL bresp_clear: got %b expected 00", {axi_done, bus_err}); end
  endtask

  task automatic test_overflow();
    logic [63:0] e;
    push_line(64'h2000_0000, 64'hC0, LB + 1, 1'b0);
    @(negedge clk);
    axi_fifo_wen = 1'b0;
    axi_req = 1'b1; axi_rw = 1'b1; axi_req_addr = 64'h2000_0000;
    serve_write(1'b0, 2'b00, lat);
    checks++;
    if (obs_w.size() != LB) begin fails++; $display("FAIL ovf_count: got %0d expected %0d", obs_w.size(), LB); end
    for (int i = 0; i < obs_w.size(); i++) begin
      checks++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      if (obs_w[i] !== e) begin fails++; $display("FAIL ovf_beat%0d: got %h expected %h", i, obs_w[i], e); end
    end
    do_ack();
    exp_q.delete();
  endtask

  task automatic test_early_rlast();
    logic [63:0] e;
    @(negedge clk);
    axi_req = 1'b1; axi_rw = 1'b0; axi_req_addr = 64'h3000_0000;
    serve_read(64'hE0, 3, lat);
    checks++;
    if (lat < 0 || {axi_done, bus_err} !== 2'b11) begin
      fails++; $display("FAIL early_rlast: got done/err %b lat %0d expected 11", {axi_done, bus_err}, lat);
    end
    for (int i = 0; i < 4; i++) begin
      axi_fifo_ridx = 3'(i);
      #1;
      checks++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      if (axi_data_o !== e) begin fails++; $display("FAIL early_rd%0d: got %h expected %h", i, axi_data_o, e); end
    end
    do_ack();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    axi_req = 1'b1; axi_rw = 1'b0; axi_req_addr = 64'h5000_0000;
    @(negedge clk);
    axi_req   = 1'b0;
    m_arready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      m_arready = 1'b0;
      m_rvalid  = 1'b1;
      m_rdata   = 64'(i);
      m_rlast   = 1'b0;
      if (i == 4) rst = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    m_rvalid = 1'b0;
    checks++;
    if ({m_rready, axi_done, m_arvalid, bus_err} !== 4'b0) begin
      fails++; $display("FAIL mid_reset: got %b expected 0000", {m_rready, axi_done, m_arvalid, bus_err});
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    @(negedge clk);
    axi_req = 1'b1; axi_rw = 1'b0; axi_req_addr = 64'h6000_0088;
    serve_read(64'h1111_0000, 7, lat);
    checks++;
    if (lat != 9 || obs_araddr !== 64'h6000_0080) begin
      fails++; $display("FAIL b2b_refill: got lat %0d addr %h expected 9 60000080", lat, obs_araddr);
    end
    for (int i = 0; i < LB; i++) begin
      axi_fifo_ridx = 3'(i);
      #1;
      checks++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      if (axi_data_o !== e) begin fails++; $display("FAIL b2b_rd%0d: got %h expected %h", i, axi_data_o, e); end
    end
    do_ack();
    push_line(64'h6000_0080, 64'h2222_0000, LB, 1'b1);
    serve_write(1'b0, 2'b00, lat);
    checks++;
    if (lat != 11 || obs_w.size() != LB) begin
      fails++; $display("FAIL b2b_wb: got lat %0d beats %0d expected 11 %0d", lat, obs_w.size(), LB);
    end
    for (int i = 0; i < obs_w.size(); i++) begin
      checks++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
      if (obs_w[i] !== e) begin fails++; $display("FAIL b2b_beat%0d: got %h expected %h", i, obs_w[i], e); end
    end
    do_ack();
    checks++;
    if ({axi_done, bus_err, m_awvalid} !== 3'b0) begin fails++; $display("FAIL b2b_idle: got %b expected 000", {axi_done, bus_err, m_awvalid}); end
  endtask

`ifdef CACHE_LINE_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int g = 0;
    @(negedge clk);
    axi_req = 1'b1; axi_rw = 1'b0; axi_req_addr = 64'h7000_0000;
    m_arready = 1'b0;
    for (g = 1; g <= 70000; g++) begin
      @(negedge clk);
      axi_req = 1'b0;
      if (axi_done) break;
    end
    checks++;
    if ({axi_done, bus_err, m_arvalid} !== 3'b110 || g < 65536 || g > 65540) begin
      fails++; $display("FAIL timeout: got done/err/arvalid %b after %0d cycles expected 110 near 65537", {axi_done, bus_err, m_arvalid}, g);
    end
    do_ack();
  endtask
`endif

  initial begin
    test_reset();
    test_refill();
    test_writeback();
    test_bresp_err();
    test_overflow();
    test_early_rlast();
    test_reset_mid_burst();
    test_back_to_back();
`ifdef CACHE_LINE_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
